// File: rtl/ooo_pkg.sv
// Shared out-of-order core definitions: machine sizing, tag types and the
// state encoding used by the RAT recovery walker.
`timescale 1ns/1ps
package ooo_pkg;

    localparam int ARCH_REGS = 32;
    localparam int ROB_DEPTH = 16;
    localparam int PHYS_REGS = 64;
    localparam int ARCH_W    = $clog2(ARCH_REGS);
    localparam int ROB_W     = $clog2(ROB_DEPTH);
    localparam int PHYS_W    = $clog2(PHYS_REGS);

    typedef logic [ROB_W-1:0]  rob_idx_t;
    typedef logic [PHYS_W-1:0] phys_tag_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } recov_state_e;

endpackage

// File: rtl/rat_recovery_walker.sv
// RAT rollback sequencer: after a mispredict, walks the squashed ROB entries
// from youngest to oldest, one per cycle, restoring each entry's previous
// mapping into the RAT and returning its allocated tag to the free list.
// Walking youngest-first leaves the oldest squashed pd_old as the final RAT
// value when several squashed entries wrote the same architectural register.
`timescale 1ns/1ps
module rat_recovery_walker #(
    parameter int ROB_DEPTH = 16,
    parameter int PHYS_REGS = 64,
    parameter int ROB_W     = $clog2(ROB_DEPTH),
    parameter int PHYS_W    = $clog2(PHYS_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mispredict_valid,
    output logic              mispredict_ready,
    input  logic [ROB_W-1:0]  mispredict_idx,
    input  logic [ROB_W-1:0]  rob_tail,
    input  logic              flush_valid,
    output logic [ROB_W-1:0]  rob_rd_idx,
    input  logic              rob_rd_uses_rd,
    input  logic [4:0]        rob_rd_arch,
    input  logic [PHYS_W-1:0] rob_rd_pd_old,
    input  logic [PHYS_W-1:0] rob_rd_pd_new,
    output logic              recover_valid,
    output logic [4:0]        recover_rd_arch,
    output logic [PHYS_W-1:0] recover_pd,
    output logic              fl_push_valid,
    output logic [PHYS_W-1:0] fl_push_pd,
    output logic              rename_stall,
    output logic              recovery_done
);
    import ooo_pkg::*;

    localparam logic [ROB_W-1:0] IDX_ONE = 1;

    recov_state_e     state_q, state_d;
    logic [ROB_W-1:0] walk_ptr_q, walk_ptr_d;
    logic [ROB_W-1:0] remaining_q, remaining_d;
    logic             entry_live;

    // Status and data paths come straight from registered state and the ROB read port
    assign mispredict_ready = (state_q == IDLE);
    assign rename_stall     = (state_q != IDLE);
    assign rob_rd_idx       = walk_ptr_q;
    assign recover_rd_arch  = rob_rd_arch;
    assign recover_pd       = rob_rd_pd_old;
    assign fl_push_pd       = rob_rd_pd_new;

    // Next-state, walk counters and strobes; a flush overrides everything else
    always_comb begin
        state_d       = state_q;
        walk_ptr_d    = walk_ptr_q;
        remaining_d   = remaining_q;
        recover_valid = 1'b0;
        fl_push_valid = 1'b0;
        recovery_done = 1'b0;
        entry_live    = rob_rd_uses_rd && (rob_rd_arch != 5'd0);

        case (state_q)
            IDLE: begin
                if (mispredict_valid) begin
                    walk_ptr_d  = rob_tail - IDX_ONE;
                    remaining_d = rob_tail - mispredict_idx - IDX_ONE;
                    state_d     = (remaining_d == '0) ? DONE : WALK;
                end
            end
            WALK: begin
                recover_valid = entry_live;
                fl_push_valid = entry_live;
                walk_ptr_d    = walk_ptr_q - IDX_ONE;
                remaining_d   = remaining_q - IDX_ONE;
                if (remaining_q == IDX_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                recovery_done = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush_valid) begin
            state_d       = IDLE;
            remaining_d   = '0;
            recover_valid = 1'b0;
            fl_push_valid = 1'b0;
            recovery_done = 1'b0;
        end
    end

    // Walk FSM state and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            walk_ptr_q  <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            walk_ptr_q  <= walk_ptr_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: tb/tb_rat_recovery_walker.sv
// Bench for rat_recovery_walker: a small ROB table answers the async read
// port, stimulus pushes hand-computed recover/done events into a scoreboard
// and a negedge monitor pops and compares them as the DUT emits them.
`timescale 1ns/1ps
module tb_rat_recovery_walker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mispredict_valid = 1'b0;
    logic       mispredict_ready;
    logic [3:0] mispredict_idx = '0;
    logic [3:0] rob_tail = '0;
    logic       flush_valid = 1'b0;
    logic [3:0] rob_rd_idx;
    logic       rob_rd_uses_rd;
    logic [4:0] rob_rd_arch;
    logic [5:0] rob_rd_pd_old;
    logic [5:0] rob_rd_pd_new;
    logic       recover_valid;
    logic [4:0] recover_rd_arch;
    logic [5:0] recover_pd;
    logic       fl_push_valid;
    logic [5:0] fl_push_pd;
    logic       rename_stall;
    logic       recovery_done;

    // ROB contents seen through the async read port
    logic       rob_uses [16];
    logic [4:0] rob_arch [16];
    logic [5:0] rob_old  [16];
    logic [5:0] rob_new  [16];

    assign rob_rd_uses_rd = rob_uses[rob_rd_idx];
    assign rob_rd_arch    = rob_arch[rob_rd_idx];
    assign rob_rd_pd_old  = rob_old[rob_rd_idx];
    assign rob_rd_pd_new  = rob_new[rob_rd_idx];

    typedef struct {
        int kind;
        int idx;
        int arch;
        int pd_old;
        int pd_new;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    sb_entry_t mon_e;
    int        checks = 0;
    int        errors = 0;
    int        rat_model [32];

    rat_recovery_walker dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mispredict_valid (mispredict_valid),
        .mispredict_ready (mispredict_ready),
        .mispredict_idx   (mispredict_idx),
        .rob_tail         (rob_tail),
        .flush_valid      (flush_valid),
        .rob_rd_idx       (rob_rd_idx),
        .rob_rd_uses_rd   (rob_rd_uses_rd),
        .rob_rd_arch      (rob_rd_arch),
        .rob_rd_pd_old    (rob_rd_pd_old),
        .rob_rd_pd_new    (rob_rd_pd_new),
        .recover_valid    (recover_valid),
        .recover_rd_arch  (recover_rd_arch),
        .recover_pd       (recover_pd),
        .fl_push_valid    (fl_push_valid),
        .fl_push_pd       (fl_push_pd),
        .rename_stall     (rename_stall),
        .recovery_done    (recovery_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, wanted %0d", name, actual, expected);
        end
    endtask

    task automatic setEntry(input int idx, input logic uses, input int arch, input int pd_old, input int pd_new);
        rob_uses[idx] = uses;
        rob_arch[idx] = 5'(arch);
        rob_old[idx]  = 6'(pd_old);
        rob_new[idx]  = 6'(pd_new);
    endtask

    task automatic pushRecover(input int idx, input int arch, input int pd_old, input int pd_new);
        sb_entry_t e;
        e.kind = 0; e.idx = idx; e.arch = arch; e.pd_old = pd_old; e.pd_new = pd_new;
        sb_q.push_back(e);
    endtask

    task automatic pushDone();
        sb_entry_t e;
        e.kind = 1; e.idx = 0; e.arch = 0; e.pd_old = 0; e.pd_new = 0;
        sb_q.push_back(e);
    endtask

    // Issue one mispredict and measure how many cycles rename stays stalled
    task automatic applyStimulus(input int tail, input int br, input int exp_stall);
        int stall_cnt;
        @(posedge clk); #1;
        checkOutput("ready_before_req", 32'(mispredict_ready), 1);
        mispredict_valid = 1'b1;
        rob_tail         = 4'(tail);
        mispredict_idx   = 4'(br);
        @(posedge clk); #1;
        mispredict_valid = 1'b0;
        stall_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!rename_stall) break;
            stall_cnt++;
        end
        checkOutput("stall_cycles", stall_cnt, exp_stall);
    endtask

    // Monitor: every strobe or done pulse must match the next scoreboard entry
    always @(negedge clk) begin
        if (rst_n) begin
            if (recover_valid || fl_push_valid) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_recover", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    checkOutput("event_kind_recover", 0, mon_e.kind);
                    checkOutput("recover_valid", 32'(recover_valid), 1);
                    checkOutput("fl_push_valid", 32'(fl_push_valid), 1);
                    checkOutput("rob_rd_idx", 32'(rob_rd_idx), mon_e.idx);
                    checkOutput("recover_rd_arch", 32'(recover_rd_arch), mon_e.arch);
                    checkOutput("recover_pd", 32'(recover_pd), mon_e.pd_old);
                    checkOutput("fl_push_pd", 32'(fl_push_pd), mon_e.pd_new);
                    rat_model[recover_rd_arch] = int'(recover_pd);
                end
            end
            if (recovery_done) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    checkOutput("event_kind_done", 1, mon_e.kind);
                    checkOutput("done_stall", 32'(rename_stall), 1);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) setEntry(i, 1'b0, 0, 0, 0);
        for (int i = 0; i < 32; i++) rat_model[i] = 0;

        // Reset values while rst_n is held low
        #2;
        checkOutput("reset_ready", 32'(mispredict_ready), 1);
        checkOutput("reset_stall", 32'(rename_stall), 0);
        checkOutput("reset_recover", 32'(recover_valid), 0);
        checkOutput("reset_flpush", 32'(fl_push_valid), 0);
        checkOutput("reset_done", 32'(recovery_done), 0);
        checkOutput("reset_rd_idx", 32'(rob_rd_idx), 0);
        #10 rst_n = 1'b1;

        // Basic walk: idx 4 (x1), 3 (x2), 2 (x0, no strobes)
        setEntry(4, 1'b1, 1, 10, 40);
        setEntry(3, 1'b1, 2, 11, 41);
        setEntry(2, 1'b1, 0, 12, 42);
        pushRecover(4, 1, 10, 40);
        pushRecover(3, 2, 11, 41);
        pushDone();
        applyStimulus(5, 1, 4);

        // Wraparound: tail=2, branch=14 walks 1, 0, 15
        setEntry(1, 1'b1, 3, 20, 50);
        setEntry(0, 1'b1, 4, 21, 51);
        setEntry(15, 1'b1, 6, 22, 52);
        pushRecover(1, 3, 20, 50);
        pushRecover(0, 4, 21, 51);
        pushRecover(15, 6, 22, 52);
        pushDone();
        applyStimulus(2, 14, 4);

        // Branch is youngest: nothing to walk, single stall cycle
        pushDone();
        applyStimulus(8, 7, 1);

        // Same arch reg twice: oldest pd_old must be the final RAT value
        setEntry(3, 1'b1, 5, 40, 60);
        setEntry(2, 1'b1, 5, 33, 61);
        pushRecover(3, 5, 40, 60);
        pushRecover(2, 5, 33, 61);
        pushDone();
        applyStimulus(4, 1, 3);
        checkOutput("rat_x5_final", rat_model[5], 33);

        // Flush during the second walk cycle aborts with no done pulse
        setEntry(4, 1'b1, 7, 24, 44);
        setEntry(3, 1'b1, 8, 25, 45);
        setEntry(2, 1'b1, 9, 26, 46);
        pushRecover(4, 7, 24, 44);
        @(posedge clk); #1;
        mispredict_valid = 1'b1;
        rob_tail         = 4'd5;
        mispredict_idx   = 4'd1;
        @(posedge clk); #1;
        mispredict_valid = 1'b0;
        @(posedge clk); #1;
        flush_valid = 1'b1;
        @(negedge clk);
        checkOutput("flush_recover", 32'(recover_valid), 0);
        checkOutput("flush_flpush", 32'(fl_push_valid), 0);
        @(posedge clk); #1;
        flush_valid = 1'b0;
        checkOutput("flush_ready", 32'(mispredict_ready), 1);
        checkOutput("flush_stall", 32'(rename_stall), 0);
        pushDone();
        applyStimulus(8, 7, 1);

        // Flush beats a same-cycle mispredict request
        @(posedge clk); #1;
        flush_valid      = 1'b1;
        mispredict_valid = 1'b1;
        rob_tail         = 4'd5;
        mispredict_idx   = 4'd1;
        @(posedge clk); #1;
        flush_valid      = 1'b0;
        mispredict_valid = 1'b0;
        checkOutput("flush_wins_ready", 32'(mispredict_ready), 1);
        checkOutput("flush_wins_stall", 32'(rename_stall), 0);

        // Async reset mid-walk returns to reset values immediately
        setEntry(4, 1'b0, 0, 0, 0);
        setEntry(3, 1'b0, 0, 0, 0);
        setEntry(2, 1'b0, 0, 0, 0);
        @(posedge clk); #1;
        mispredict_valid = 1'b1;
        rob_tail         = 4'd5;
        mispredict_idx   = 4'd1;
        @(posedge clk); #1;
        mispredict_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_ready", 32'(mispredict_ready), 1);
        checkOutput("midreset_stall", 32'(rename_stall), 0);
        checkOutput("midreset_recover", 32'(recover_valid), 0);
        checkOutput("midreset_flpush", 32'(fl_push_valid), 0);
        checkOutput("midreset_done", 32'(recovery_done), 0);
        checkOutput("midreset_rd_idx", 32'(rob_rd_idx), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_stall", 32'(rename_stall), 0);

        repeat (3) @(posedge clk);
        checkOutput("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
